// File: rtl/miner_pkg.sv
// Shared definitions for the SHA3-256 mining core: control/status bit
// positions, the nonce sequencer state type and default widths.
package miner_pkg;

  localparam int NONCE_W_DEFAULT = 64;
  localparam int HASH_W_DEFAULT  = 256;

  localparam int CTL_RUN  = 0;
  localparam int CTL_TEST = 1;
  localparam int CTL_HALT = 2;

  localparam int ST_FOUND = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_TEST  = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

endpackage

// File: rtl/miner_inflight_cnt.sv
// Counts nonces issued to the hash pipeline that have not yet come back.
// A return while nothing is outstanding is dropped so the count cannot wrap.
module miner_inflight_cnt #(
  parameter int MAX_INFLIGHT = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o,
  output logic last_o
);

  localparam int            CW    = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_INFLIGHT);

  logic [CW-1:0] count_q, count_d;
  logic          dec_ok;

  assign dec_ok = dec_i & (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (inc_i & ~dec_ok) begin
      count_d = count_q + CW'(1);
    end else if (dec_ok & ~inc_i) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign full_o  = (count_q >= MAX_C);
  assign empty_o = (count_q == '0);
  assign last_o  = (count_q == CW'(1));

endmodule

// File: rtl/miner_nonce_ctl.sv
// Nonce sequencer and result checker: issues consecutive nonces to the hash
// pipeline, compares returned digests with the difficulty and keeps the first win.
module miner_nonce_ctl
  import miner_pkg::*;
#(
  parameter int NONCE_W      = NONCE_W_DEFAULT,
  parameter int HASH_W       = HASH_W_DEFAULT,
  parameter int MAX_INFLIGHT = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NONCE_W-1:0] start_nonce,
  input  logic [HASH_W-1:0]  difficulty,
  input  logic [18:0]        control,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [NONCE_W-1:0] issue_nonce,
  input  logic               res_valid,
  input  logic [NONCE_W-1:0] res_nonce,
  input  logic [HASH_W-1:0]  res_digest,
  output logic [NONCE_W-1:0] solution,
  output logic [2:0]         status,
  output logic               irq
);

  state_e             state_q, state_d;
  logic [NONCE_W-1:0] counter_q, counter_d;
  logic [NONCE_W-1:0] solution_q, solution_d;
  logic               found_q, found_d;
  logic               run_prev_q;

  logic run, test, halt, run_rise, running;
  logic issue_hs, res_ok, win;
  logic inf_full, inf_empty, inf_last;
  logic ctl_pad_unused;

  assign run            = control[CTL_RUN];
  assign test           = control[CTL_TEST];
  assign halt           = control[CTL_HALT];
  assign ctl_pad_unused = ^control[18:3];
  assign run_rise       = run & ~run_prev_q;

  assign issue_valid = (state_q == S_RUN) & ~halt & ~inf_full;
  assign issue_nonce = counter_q;
  assign issue_hs    = issue_valid & issue_ready;

  // Stray results with nothing outstanding are treated as if never seen.
  assign res_ok = res_valid & ~inf_empty;
  assign win    = res_ok & (test | (res_digest < difficulty));

  miner_inflight_cnt #(
    .MAX_INFLIGHT(MAX_INFLIGHT)
  ) u_inflight (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (issue_hs),
    .dec_i  (res_valid),
    .full_o (inf_full),
    .empty_o(inf_empty),
    .last_o (inf_last)
  );

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    found_d    = found_q;
    solution_d = solution_q;
    case (state_q)
      S_IDLE: begin
        if (run_rise) begin
          counter_d  = start_nonce;
          found_d    = 1'b0;
          solution_d = '0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (issue_hs) begin
          counter_d = counter_q + NONCE_W'(1);
        end
        if (win) begin
          solution_d = res_nonce;
          found_d    = 1'b1;
          state_d    = S_DRAIN;
        end else if (!run) begin
          state_d = S_DRAIN;
        end
      end
      // Leave as soon as the last outstanding result is being returned.
      S_DRAIN: begin
        if (inf_empty | (inf_last & res_ok)) begin
          state_d = found_q ? S_DONE : S_IDLE;
        end
      end
      S_DONE: begin
        if (!run) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      counter_q  <= '0;
      solution_q <= '0;
      found_q    <= 1'b0;
      run_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      solution_q <= solution_d;
      found_q    <= found_d;
      run_prev_q <= run;
    end
  end

  assign running = (state_q == S_RUN) | (state_q == S_DRAIN);

  always_comb begin
    status           = '0;
    status[ST_FOUND] = found_q;
    status[ST_RUN]   = running;
    status[ST_TEST]  = test & running;
  end

  assign solution = solution_q;
  assign irq      = found_q;

endmodule

// File: tb/tb_miner_nonce_ctl.sv
// Randomised self-checking bench for miner_nonce_ctl with a behavioural hash
// pipeline that records every issued nonce and every returned result.
module tb_miner_nonce_ctl;

  localparam int NW   = 64;
  localparam int HW   = 256;
  localparam int MAXI = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NW-1:0] start_nonce;
  logic [HW-1:0] difficulty;
  logic [18:0]   control;
  logic          issue_valid, issue_ready;
  logic [NW-1:0] issue_nonce;
  logic          res_valid;
  logic [NW-1:0] res_nonce;
  logic [HW-1:0] res_digest;
  logic [NW-1:0] solution;
  logic [2:0]    status;
  logic          irq;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [NW-1:0] nonce;
    logic [HW-1:0] digest;
    int            due;
  } entry_t;

  entry_t        pipeQ[$];
  entry_t        retQ[$];
  logic [NW-1:0] issuedQ[$];
  entry_t        pe;
  int            cyc      = 0;
  int            pipeLat  = 3;
  int            relCount = 0;
  bit            pipeEn   = 1'b1;
  bit            digRand  = 1'b1;
  logic [HW-1:0] digConst = '0;

  miner_nonce_ctl #(
    .NONCE_W(NW),
    .HASH_W(HW),
    .MAX_INFLIGHT(MAXI)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_nonce(start_nonce),
    .difficulty (difficulty),
    .control    (control),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .issue_nonce(issue_nonce),
    .res_valid  (res_valid),
    .res_nonce  (res_nonce),
    .res_digest (res_digest),
    .solution   (solution),
    .status     (status),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  function automatic logic [HW-1:0] randDigest();
    logic [HW-1:0] d;
    for (int i = 0; i < HW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Hash pipeline model: decides at the falling edge what the next rising edge sees.
  always @(negedge clk) begin
    cyc++;
    res_valid = 1'b0;
    if (pipeQ.size() > 0 && ((pipeEn && pipeQ[0].due <= cyc) || (!pipeEn && relCount > 0))) begin
      pe = pipeQ.pop_front();
      res_valid  = 1'b1;
      res_nonce  = pe.nonce;
      res_digest = pe.digest;
      retQ.push_back(pe);
      if (!pipeEn) relCount--;
    end
    if (issue_valid === 1'b1 && issue_ready === 1'b1 && rst === 1'b0) begin
      pe.nonce  = issue_nonce;
      pe.digest = digRand ? randDigest() : digConst;
      pe.due    = cyc + pipeLat;
      pipeQ.push_back(pe);
      issuedQ.push_back(issue_nonce);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearQ();
    pipeQ.delete();
    retQ.delete();
    issuedQ.delete();
    relCount = 0;
  endtask

  function automatic int firstWin(int from, int upto, bit tm);
    for (int i = from; i < upto; i++)
      if (tm || retQ[i].digest < difficulty) return i;
    return -1;
  endfunction

  task automatic waitNotRunning(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (status[1] === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic waitIrq(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (irq === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_issue_valid got=%b want=0", issue_valid); end
    total++; if (status !== 3'b000) begin bad++; $display("[TB] FAIL reset_status got=%b want=000", status); end
    total++; if (solution !== '0) begin bad++; $display("[TB] FAIL reset_solution got=%h want=0", solution); end
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL reset_irq got=%b want=0", irq); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_start();
    bit ok;
    int w;
    clearQ();
    start_nonce = 64'h10; difficulty = '1; digRand = 1'b1; pipeLat = 3; pipeEn = 1'b1;
    issue_ready = 1'b1; control = 19'b001;
    waitIrq(50, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL start_found_timeout got=irq0 want=irq1"); end
    total++; if (retQ.size() != 1) begin bad++; $display("[TB] FAIL start_found_latency got=%0d results want=1", retQ.size()); end
    w = firstWin(0, retQ.size(), 1'b0);
    total++; if (w < 0 || solution !== retQ[w].nonce) begin bad++; $display("[TB] FAIL start_solution got=%h want=%h", solution, start_nonce); end
    waitNotRunning(50, ok);
    total++; if (!ok || issuedQ.size() != retQ.size()) begin bad++; $display("[TB] FAIL start_drain got=%0d/%0d want all returned", retQ.size(), issuedQ.size()); end
    for (int i = 0; i < issuedQ.size(); i++) begin
      total++; if (issuedQ[i] !== start_nonce + NW'(i)) begin bad++; $display("[TB] FAIL start_nonce_seq got=%h want=%h", issuedQ[i], start_nonce + NW'(i)); end
    end
    total++; if (status !== 3'b001 || issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL start_done_status got=%b/%b want=001/0", status, issue_valid); end
    control = '0;
    repeat (3) tick();
    total++; if (status !== 3'b001 || solution !== 64'h10) begin bad++; $display("[TB] FAIL start_idle_hold got=%b/%h want=001/10", status, solution); end
  endtask

  task automatic test_wrap();
    bit ok;
    clearQ();
    start_nonce = 64'hFFFF_FFFF_FFFF_FFFE; difficulty = '0; digRand = 1'b1;
    issue_ready = 1'b1; control = 19'b001;
    repeat (12) tick();
    total++; if (issuedQ.size() < 4) begin bad++; $display("[TB] FAIL wrap_count got=%0d want>=4", issuedQ.size()); end
    for (int i = 0; i < issuedQ.size() && i < 6; i++) begin
      total++; if (issuedQ[i] !== start_nonce + NW'(i)) begin bad++; $display("[TB] FAIL wrap_nonce got=%h want=%h", issuedQ[i], start_nonce + NW'(i)); end
    end
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL wrap_no_found got=%b want=0", irq); end
    control = '0;
    tick();
    waitNotRunning(50, ok);
    total++; if (!ok || status !== 3'b000 || issuedQ.size() != retQ.size()) begin bad++; $display("[TB] FAIL wrap_drain got=%b %0d/%0d want=000 all returned", status, retQ.size(), issuedQ.size()); end
    tick();
  endtask

  task automatic test_backpressure();
    bit ok;
    clearQ();
    start_nonce = {$urandom, $urandom}; difficulty = '0; pipeEn = 1'b0;
    issue_ready = 1'b1; control = 19'b001;
    repeat (10) tick();
    total++; if (issuedQ.size() != MAXI || issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_fill got=%0d/%b want=%0d/0", issuedQ.size(), issue_valid, MAXI); end
    relCount = 1;
    repeat (6) tick();
    total++; if (issuedQ.size() != MAXI + 1 || issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_one_slot got=%0d/%b want=%0d/0", issuedQ.size(), issue_valid, MAXI + 1); end
    relCount = 2;
    repeat (6) tick();
    total++; if (issuedQ.size() - retQ.size() != MAXI || issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_simultaneous got=%0d outstanding want=%0d", issuedQ.size() - retQ.size(), MAXI); end
    total++; if (issuedQ.size() != MAXI + 3) begin bad++; $display("[TB] FAIL bp_issue_total got=%0d want=%0d", issuedQ.size(), MAXI + 3); end
    for (int i = 0; i < issuedQ.size(); i++) begin
      total++; if (issuedQ[i] !== start_nonce + NW'(i)) begin bad++; $display("[TB] FAIL bp_nonce got=%h want=%h", issuedQ[i], start_nonce + NW'(i)); end
    end
    pipeEn = 1'b1; control = '0;
    tick();
    waitNotRunning(50, ok);
    total++; if (!ok || status !== 3'b000) begin bad++; $display("[TB] FAIL bp_drain got=%b want=000", status); end
    tick();
  endtask

  task automatic test_halt();
    bit ok;
    int viol, mark, w, n;
    clearQ();
    start_nonce = {$urandom, $urandom}; difficulty = '0; digRand = 1'b1; pipeLat = 3; pipeEn = 1'b1;
    issue_ready = 1'b1; control = 19'b001;
    for (int i = 0; i < 30 && issuedQ.size() < 5; i++) tick();
    control = 19'b101;
    viol = 0;
    repeat (6) begin tick(); if (issue_valid !== 1'b0) viol++; end
    total++; if (viol != 0 || issuedQ.size() != 5) begin bad++; $display("[TB] FAIL halt_stop got=%0d issued %0d valid want=5 0", issuedQ.size(), viol); end
    control = 19'b001;
    for (int i = 0; i < 20 && issuedQ.size() <= 5; i++) tick();
    total++; if (issuedQ.size() <= 5 || issuedQ[5] !== start_nonce + NW'(5)) begin bad++; $display("[TB] FAIL halt_resume got=%0d issued want nonce %h", issuedQ.size(), start_nonce + NW'(5)); end
    tick(); tick();
    control = 19'b101; difficulty = '1;
    mark = retQ.size();
    viol = 0; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (issue_valid !== 1'b0) viol++;
      if (irq === 1'b1) begin ok = 1'b1; break; end
    end
    total++; if (!ok || viol != 0) begin bad++; $display("[TB] FAIL halt_win_latch got=irq%b valid%0d want=irq1 valid0", irq, viol); end
    w = firstWin(mark, retQ.size(), 1'b0);
    total++; if (w < 0 || solution !== retQ[w].nonce) begin bad++; $display("[TB] FAIL halt_solution got=%h want=first win after halt", solution); end
    n = issuedQ.size();
    control = 19'b001;
    repeat (3) tick();
    total++; if (issue_valid !== 1'b0 || issuedQ.size() != n) begin bad++; $display("[TB] FAIL halt_no_resume_after_found got=%b/%0d want=0/%0d", issue_valid, issuedQ.size(), n); end
    control = '0;
    waitNotRunning(50, ok);
    tick(); tick();
  endtask

  task automatic test_testmode();
    bit ok;
    clearQ();
    start_nonce = {$urandom, $urandom}; difficulty = '0; pipeLat = 3; pipeEn = 1'b1;
    issue_ready = 1'b1; control = 19'b011;
    waitIrq(30, ok);
    total++; if (!ok || solution !== start_nonce) begin bad++; $display("[TB] FAIL test_solution got=%h want=%h", solution, start_nonce); end
    total++; if (status !== 3'b111) begin bad++; $display("[TB] FAIL test_status_drain got=%b want=111", status); end
    waitNotRunning(50, ok);
    total++; if (!ok || status !== 3'b001) begin bad++; $display("[TB] FAIL test_status_done got=%b want=001", status); end
    control = '0;
    tick(); tick();
  endtask

  task automatic test_reset_midrun();
    bit ok;
    int viol;
    clearQ();
    start_nonce = {$urandom, $urandom}; difficulty = '0; pipeLat = 3; pipeEn = 1'b1;
    issue_ready = 1'b1; control = 19'b001;
    for (int i = 0; i < 30 && (issuedQ.size() - retQ.size()) < 3; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    total++; if (issue_valid !== 1'b0 || status !== 3'b000) begin bad++; $display("[TB] FAIL midreset_outputs got=%b/%b want=0/000", issue_valid, status); end
    total++; if (irq !== 1'b0 || solution !== '0) begin bad++; $display("[TB] FAIL midreset_result got=%b/%h want=0/0", irq, solution); end
    control = '0; difficulty = '1;
    tick();
    rst = 1'b0;
    viol = 0;
    repeat (6) begin tick(); if (irq !== 1'b0 || status !== 3'b000) viol++; end
    total++; if (viol != 0) begin bad++; $display("[TB] FAIL midreset_stale_ignored got=%0d bad cycles want=0", viol); end
    for (int i = 0; i < 20 && pipeQ.size() > 0; i++) tick();
    clearQ();
    pipeEn = 1'b0; difficulty = '0; control = 19'b001;
    repeat (10) tick();
    total++; if (issuedQ.size() != MAXI) begin bad++; $display("[TB] FAIL midreset_inflight_zero got=%0d issues want=%0d", issuedQ.size(), MAXI); end
    pipeEn = 1'b1; control = '0;
    tick();
    waitNotRunning(50, ok);
    tick();
  endtask

  task automatic test_back_to_back();
    bit ok;
    clearQ();
    start_nonce = {$urandom, $urandom}; difficulty = HW'(1); digRand = 1'b0; digConst = '0;
    pipeLat = 3; issue_ready = 1'b1; control = 19'b001;
    waitIrq(30, ok);
    repeat (4) tick();
    total++; if (!ok || solution !== start_nonce || retQ.size() < 2) begin bad++; $display("[TB] FAIL b2b_first_kept got=%h want=%h", solution, start_nonce); end
    waitNotRunning(50, ok);
    total++; if (solution !== start_nonce || status !== 3'b001) begin bad++; $display("[TB] FAIL b2b_done got=%h/%b want=%h/001", solution, status, start_nonce); end
    digRand = 1'b1; control = '0;
    tick(); tick();
  endtask

  task automatic test_random();
    bit ok;
    int windowEnd, w;
    for (int it = 0; it < 6; it++) begin
      clearQ();
      start_nonce = {$urandom, $urandom};
      difficulty  = randDigest() >> $urandom_range(0, 5);
      pipeLat     = $urandom_range(1, 6);
      pipeEn      = 1'b1; digRand = 1'b1;
      control     = 19'b001;
      for (int c = 0; c < 60; c++) begin
        issue_ready = 1'($urandom_range(0, 1));
        tick();
        if (irq === 1'b1) break;
      end
      issue_ready = 1'b1;
      control = '0;
      tick();
      windowEnd = retQ.size();
      waitNotRunning(60, ok);
      w = firstWin(0, windowEnd, 1'b0);
      total++; if (!ok || issuedQ.size() != retQ.size()) begin bad++; $display("[TB] FAIL rand_drain it=%0d got=%0d/%0d want all returned", it, retQ.size(), issuedQ.size()); end
      total++; if (irq !== (w >= 0)) begin bad++; $display("[TB] FAIL rand_found it=%0d got=%b want=%b", it, irq, (w >= 0)); end
      if (w >= 0) begin
        total++; if (solution !== retQ[w].nonce) begin bad++; $display("[TB] FAIL rand_solution it=%0d got=%h want=%h", it, solution, retQ[w].nonce); end
      end
      for (int i = 0; i < issuedQ.size(); i++) begin
        total++; if (issuedQ[i] !== start_nonce + NW'(i)) begin bad++; $display("[TB] FAIL rand_nonce it=%0d got=%h want=%h", it, issuedQ[i], start_nonce + NW'(i)); end
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; control = '0; start_nonce = '0; difficulty = '0; issue_ready = 1'b0;
    res_valid = 1'b0; res_nonce = '0; res_digest = '0;
    test_reset();
    test_start();
    test_wrap();
    test_backpressure();
    test_halt();
    test_testmode();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
